// File: rtl/axis_framer_esc.sv
// axis_framer_esc: wraps each tlast-delimited AXI4-Stream packet as
// START [ID] payload STOP, escaping delimiter/escape values in ID and payload.
// Output is a single registered byte; there is no frame buffer.
module axis_framer_esc #(
  parameter logic [7:0] START_BYTE = 8'h7D,
  parameter logic [7:0] STOP_BYTE  = 8'h7E,
  parameter logic [7:0] ESC_BYTE   = 8'h7F,
  parameter logic [7:0] ESC_XOR    = 8'h20,
  parameter bit         ESCAPE_EN  = 1'b1,
  parameter bit         ID_EN      = 1'b0,
  parameter int         CNT_WIDTH  = 16
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 target_tvalid,
  output logic                 target_tready,
  input  logic [7:0]           target_tdata,
  input  logic                 target_tlast,
  input  logic [7:0]           target_tid,
  output logic                 initiator_tvalid,
  input  logic                 initiator_tready,
  output logic [7:0]           initiator_tdata,
  output logic [CNT_WIDTH-1:0] frame_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ID,
    S_DATA,
    S_ESC_PEND,
    S_STOP
  } state_t;

  state_t     state_q, state_d;
  state_t     ret_q, ret_d;
  logic [7:0] id_q, id_d;
  logic [7:0] pend_q, pend_d;

  logic       slot_free;
  logic       load;
  logic [7:0] load_data;
  logic       load_delim;
  logic       delim_q;

  // True when a byte must be sent as ESC followed by (byte ^ ESC_XOR).
  function automatic logic esc_needed(input logic [7:0] b);
    return ESCAPE_EN && (b == START_BYTE || b == STOP_BYTE || b == ESC_BYTE);
  endfunction

  assign slot_free = !initiator_tvalid || initiator_tready;

  // Next-state, output-byte selection and input handshake.
  always_comb begin
    state_d       = state_q;
    ret_d         = ret_q;
    id_d          = id_q;
    pend_d        = pend_q;
    load          = 1'b0;
    load_data     = 8'h00;
    load_delim    = 1'b0;
    target_tready = 1'b0;
    case (state_q)
      S_IDLE: begin
        // The first beat only triggers START; it is consumed later in DATA.
        if (target_tvalid && slot_free) begin
          load      = 1'b1;
          load_data = START_BYTE;
          id_d      = target_tid;
          state_d   = ID_EN ? S_ID : S_DATA;
        end
      end
      S_ID: begin
        if (slot_free) begin
          load = 1'b1;
          if (esc_needed(id_q)) begin
            load_data = ESC_BYTE;
            pend_d    = id_q ^ ESC_XOR;
            ret_d     = S_DATA;
            state_d   = S_ESC_PEND;
          end else begin
            load_data = id_q;
            state_d   = S_DATA;
          end
        end
      end
      S_DATA: begin
        target_tready = slot_free;
        if (target_tvalid && slot_free) begin
          load = 1'b1;
          if (esc_needed(target_tdata)) begin
            load_data = ESC_BYTE;
            pend_d    = target_tdata ^ ESC_XOR;
            ret_d     = target_tlast ? S_STOP : S_DATA;
            state_d   = S_ESC_PEND;
          end else begin
            load_data = target_tdata;
            state_d   = target_tlast ? S_STOP : S_DATA;
          end
        end
      end
      S_ESC_PEND: begin
        if (slot_free) begin
          load      = 1'b1;
          load_data = pend_q;
          state_d   = ret_q;
        end
      end
      S_STOP: begin
        if (slot_free) begin
          load       = 1'b1;
          load_data  = STOP_BYTE;
          load_delim = 1'b1;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state, latched ID and pending escaped byte.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= S_IDLE;
      ret_q   <= S_DATA;
      id_q    <= 8'h00;
      pend_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      id_q    <= id_d;
      pend_q  <= pend_d;
    end
  end

  // Output byte register: loads when the slot is free, clears valid on handshake.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      initiator_tvalid <= 1'b0;
      initiator_tdata  <= 8'h00;
      delim_q          <= 1'b0;
    end else if (load) begin
      initiator_tvalid <= 1'b1;
      initiator_tdata  <= load_data;
      delim_q          <= load_delim;
    end else if (initiator_tready) begin
      initiator_tvalid <= 1'b0;
    end
  end

  // Frame counter: counts delimiter STOPs (not payload bytes equal to STOP).
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      frame_count <= '0;
    end else if (initiator_tvalid && initiator_tready && delim_q) begin
      frame_count <= frame_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_axis_framer_esc.sv
// Bench for axis_framer_esc: table vectors on the default configuration,
// hand sequences for ID / raw / reset cases, random packets checked by deframing.
module tb_axis_framer_esc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        tv [3];
  logic        tr [3];
  logic [7:0]  td [3];
  logic        tl [3];
  logic [7:0]  tidr [3];
  logic        ov [3];
  logic [7:0]  od [3];
  logic [15:0] fc0, fc1;
  logic [1:0]  fc2;
  logic        rdy0, rdy1, rdy2;
  logic        rnd_bit = 1'b1;
  logic        rand_rdy = 1'b0;
  logic        hold_chk = 1'b0;
  int          cyc = 0;

  int vectors = 0;
  int miscompares = 0;
  int hold_bad = 0;

  logic [7:0] cap0[$], cap1[$], cap2[$];
  int         capt0[$];
  int         rd [3];
  logic [7:0] pkt[$];
  int         acc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  assign rdy0 = rand_rdy ? rnd_bit : 1'b1;
  assign rdy1 = 1'b1;
  assign rdy2 = 1'b1;

  axis_framer_esc u_def (
    .aclk(clk), .aresetn(rstn),
    .target_tvalid(tv[0]), .target_tready(tr[0]), .target_tdata(td[0]),
    .target_tlast(tl[0]), .target_tid(tidr[0]),
    .initiator_tvalid(ov[0]), .initiator_tready(rdy0), .initiator_tdata(od[0]),
    .frame_count(fc0)
  );

  axis_framer_esc #(.ID_EN(1'b1)) u_id (
    .aclk(clk), .aresetn(rstn),
    .target_tvalid(tv[1]), .target_tready(tr[1]), .target_tdata(td[1]),
    .target_tlast(tl[1]), .target_tid(tidr[1]),
    .initiator_tvalid(ov[1]), .initiator_tready(rdy1), .initiator_tdata(od[1]),
    .frame_count(fc1)
  );

  axis_framer_esc #(.ESCAPE_EN(1'b0), .CNT_WIDTH(2)) u_raw (
    .aclk(clk), .aresetn(rstn),
    .target_tvalid(tv[2]), .target_tready(tr[2]), .target_tdata(td[2]),
    .target_tlast(tl[2]), .target_tid(tidr[2]),
    .initiator_tvalid(ov[2]), .initiator_tready(rdy2), .initiator_tdata(od[2]),
    .frame_count(fc2)
  );

  // Output monitor: records handshaked bytes and checks hold stability on u_def.
  logic       pv = 1'b0, pr = 1'b0;
  logic [7:0] pd = 8'h00;
  always @(negedge clk) begin
    if (ov[0] && rdy0) begin cap0.push_back(od[0]); capt0.push_back(cyc); end
    if (ov[1] && rdy1) cap1.push_back(od[1]);
    if (ov[2] && rdy2) cap2.push_back(od[2]);
    if (hold_chk && rstn && pv && !pr && (!ov[0] || od[0] !== pd)) begin
      hold_bad++;
      $display("FAIL hold_stable: got v=%0b d=%h required v=1 d=%h", ov[0], od[0], pd);
    end
    pv = ov[0]; pr = rdy0; pd = od[0];
  end

  function automatic int cap_size(input int d);
    case (d)
      0: return cap0.size();
      1: return cap1.size();
      default: return cap2.size();
    endcase
  endfunction

  function automatic logic [7:0] cap_at(input int d, input int k);
    case (d)
      0: return cap0[k];
      1: return cap1[k];
      default: return cap2[k];
    endcase
  endfunction

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] req);
    vectors++;
    if (got !== req) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", nm, got, req);
    end
  endtask

  // Drive pkt[] on device d, one beat held until accepted; accept cycles go to acc[].
  task automatic send(input int d, input logic [7:0] idv);
    int n;
    acc.delete();
    for (int k = 0; k < pkt.size(); k++) begin
      tv[d] = 1'b1; td[d] = pkt[k]; tl[d] = (k == pkt.size() - 1); tidr[d] = idv;
      n = 0;
      @(negedge clk);
      while (!tr[d] && n < 500) begin n++; @(negedge clk); end
      if (n >= 500) begin
        miscompares++; vectors++;
        $display("FAIL send_timeout: dev %0d beat %0d never accepted", d, k);
      end
      acc.push_back(cyc);
      @(posedge clk); #1;
    end
    tv[d] = 1'b0; tl[d] = 1'b0;
  endtask

  task automatic wait_cap(input int d, input int n);
    int t = 0;
    while (cap_size(d) - rd[d] < n && t < 300) begin @(posedge clk); #1; t++; end
    if (t >= 300) begin
      miscompares++; vectors++;
      $display("FAIL wait_out: dev %0d got %0d bytes required %0d", d, cap_size(d) - rd[d], n);
    end
  endtask

  // Compare the next n captured bytes of device d against e, then consume them.
  task automatic chk_stream(input int d, input logic [0:9][7:0] e, input int n, input string nm);
    check({nm, "_len"}, cap_size(d) - rd[d], n);
    for (int k = 0; k < n && rd[d] + k < cap_size(d); k++)
      check($sformatf("%s_b%0d", nm, k), cap_at(d, rd[d] + k), e[k]);
    rd[d] = cap_size(d);
  endtask

  typedef struct {
    logic [0:3][7:0] pl;
    int              plen;
    logic [0:9][7:0] ex;
    int              elen;
    int              span;
  } vec_t;

  vec_t vt [5];

  initial begin
    logic [0:9][7:0] e;
    logic [15:0] fcb;
    int gap_ok;
    logic [7:0] sent_bytes[$];
    int sent_lens[$];
    logic [7:0] cur[$];
    int inf, esc, fr, off, ok, t;
    logic [7:0] b;

    vt[0] = '{{8'h01, 8'h02, 8'h03, 8'h00}, 3, {8'h7D, 8'h01, 8'h02, 8'h03, 8'h7E, 40'h0}, 5, 2};
    vt[1] = '{{8'h7D, 8'h7E, 8'h7F, 8'h00}, 3,
              {8'h7D, 8'h7F, 8'h5D, 8'h7F, 8'h5E, 8'h7F, 8'h5F, 8'h7E, 16'h0}, 8, 4};
    vt[2] = '{{8'h7E, 8'h00, 8'h00, 8'h00}, 1, {8'h7D, 8'h7F, 8'h5E, 8'h7E, 48'h0}, 4, 0};
    vt[3] = '{{8'h00, 8'hFF, 8'h00, 8'h00}, 2, {8'h7D, 8'h00, 8'hFF, 8'h7E, 48'h0}, 4, 1};
    vt[4] = '{{8'h5D, 8'h00, 8'h00, 8'h00}, 1, {8'h7D, 8'h5D, 8'h7E, 56'h0}, 3, 0};

    for (int d = 0; d < 3; d++) begin tv[d] = 0; td[d] = 0; tl[d] = 0; tidr[d] = 0; rd[d] = 0; end
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", ov[0], 0);
    check("rst_tdata", od[0], 0);
    check("rst_count", fc0, 0);
    check("rst_tready", tr[0], 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Table vectors on the default configuration, downstream always ready.
    for (int i = 0; i < 5; i++) begin
      pkt.delete();
      for (int k = 0; k < vt[i].plen; k++) pkt.push_back(vt[i].pl[k]);
      fcb = fc0;
      send(0, 8'h00);
      wait_cap(0, vt[i].elen);
      gap_ok = 1;
      for (int k = 1; k < vt[i].elen && rd[0] + k < capt0.size(); k++)
        if (capt0[rd[0] + k] != capt0[rd[0]] + k) gap_ok = 0;
      check($sformatf("v%0d_no_gaps", i), gap_ok, 1);
      check($sformatf("v%0d_accept_span", i), acc[acc.size() - 1] - acc[0], vt[i].span);
      chk_stream(0, vt[i].ex, vt[i].elen, $sformatf("v%0d", i));
      check($sformatf("v%0d_count", i), fc0, fcb + 16'd1);
    end

    // ID header insertion, escaped ID and escaped single last byte.
    pkt.delete(); pkt.push_back(8'hAA);
    send(1, 8'h7E);
    wait_cap(1, 5);
    e = {8'h7D, 8'h7F, 8'h5E, 8'hAA, 8'h7E, 40'h0};
    chk_stream(1, e, 5, "id_esc");
    pkt.delete(); pkt.push_back(8'h7D);
    send(1, 8'h11);
    wait_cap(1, 5);
    e = {8'h7D, 8'h11, 8'h7F, 8'h5D, 8'h7E, 40'h0};
    chk_stream(1, e, 5, "id_last_esc");
    check("id_count", fc1, 2);

    // Raw framing and 2-bit counter wrap.
    for (int f = 0; f < 4; f++) begin
      pkt.delete(); pkt.push_back(8'h7D);
      send(2, 8'h00);
      wait_cap(2, 3);
      e = {8'h7D, 8'h7D, 8'h7E, 56'h0};
      chk_stream(2, e, 3, $sformatf("raw%0d", f));
      check($sformatf("raw_count%0d", f), 32'(fc2), (f + 1) % 4);
    end

    // Random packets with random downstream backpressure.
    fcb = fc0;
    rand_rdy = 1'b1;
    hold_chk = 1'b1;
    for (int p = 0; p < 200; p++) begin
      pkt.delete();
      t = $urandom_range(1, 8);
      for (int k = 0; k < t; k++) begin
        if ($urandom_range(0, 3) == 0) b = 8'(8'h7D + $urandom_range(0, 2));
        else b = 8'($urandom_range(0, 255));
        pkt.push_back(b);
        sent_bytes.push_back(b);
      end
      sent_lens.push_back(t);
      send(0, 8'h00);
    end
    t = 0;
    while (fc0 != fcb + 16'd200 && t < 20000) begin @(posedge clk); #1; t++; end
    check("rand_count", fc0, fcb + 16'd200);
    hold_chk = 1'b0;
    rand_rdy = 1'b0;
    check("hold_violations", hold_bad, 0);

    // Deframe the captured stream and compare packet by packet.
    inf = 0; esc = 0; fr = 0; off = 0;
    for (int j = rd[0]; j < cap0.size(); j++) begin
      b = cap0[j];
      if (inf == 0) begin
        if (b == 8'h7D) begin inf = 1; cur.delete(); end
      end else if (esc != 0) begin
        cur.push_back(b ^ 8'h20); esc = 0;
      end else if (b == 8'h7F) begin
        esc = 1;
      end else if (b == 8'h7E) begin
        ok = (fr < 200) ? 1 : 0;
        if (ok != 0 && cur.size() != sent_lens[fr]) ok = 0;
        for (int k = 0; ok != 0 && k < cur.size(); k++)
          if (cur[k] != sent_bytes[off + k]) ok = 0;
        check($sformatf("rand_pkt%0d", fr), ok, 1);
        if (fr < 200) off += sent_lens[fr];
        fr++; inf = 0;
      end else begin
        cur.push_back(b);
      end
    end
    check("rand_frames", fr, 200);
    rd[0] = cap0.size();

    // Asynchronous reset in the middle of a payload.
    tv[0] = 1'b1; td[0] = 8'h01; tl[0] = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("midrst_tvalid", ov[0], 0);
    check("midrst_count", fc0, 0);
    tv[0] = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    rd[0] = cap0.size();
    pkt.delete(); pkt.push_back(8'h09);
    send(0, 8'h00);
    wait_cap(0, 3);
    e = {8'h7D, 8'h09, 8'h7E, 56'h0};
    chk_stream(0, e, 3, "after_rst");
    check("after_rst_count", fc0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
